// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_ctrl_pkg;

    localparam int InstAddrBus = 32;
    localparam int FetchDataW  = 64;

    localparam logic RstEnable  = 1'b1;
    localparam logic ChipEnable = 1'b1;
    localparam logic NoStop     = 1'b0;
    localparam logic Branch     = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DROP = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_timeout_cnt.sv
// Clearable saturating cycle counter; flags expiry at TIMEOUT-1.
module fetch_timeout_cnt
    import fetch_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             expired_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign expired_o = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: one 64-bit request per PC, waits for ack, drops
// in-flight fetches on flush/redirect and abandons them on timeout.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [InstAddrBus-1:0] pc_i,
    input  logic                   ce_i,
    input  logic [5:0]             stall_i,
    input  logic                   flush_i,
    input  logic                   branch_flag_i,
    output logic                   ibus_req_o,
    output logic [InstAddrBus-1:0] ibus_addr_o,
    input  logic                   ibus_ack_i,
    input  logic [FetchDataW-1:0]  ibus_rdata_i,
    output logic [FetchDataW-1:0]  inst_o,
    output logic [InstAddrBus-1:0] inst_addr_o,
    output logic                   inst_valid_o,
    output logic                   stallreq_o,
    output logic                   ibus_err_o,
    output logic                   align_err_o
);

    fetch_state_e           state_q, state_d;
    logic                   req_q, req_d;
    logic [InstAddrBus-1:0] addr_q, addr_d;
    logic [FetchDataW-1:0]  inst_q, inst_d;
    logic [InstAddrBus-1:0] iaddr_q, iaddr_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;
    logic                   aerr_q, aerr_d;

    logic             expired;
    logic [CNT_W-1:0] cnt;
    logic             dec_stall;
    logic             redirect;
    logic             unused_sig;

    assign dec_stall  = (stall_i[1] != NoStop);
    assign redirect   = flush_i || (branch_flag_i == Branch);
    assign unused_sig = ^{stall_i[5:2], stall_i[0], cnt};

    fetch_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (state_q == IDLE),
        .en_i      ((state_q == BUSY) || (state_q == DROP)),
        .cnt_o     (cnt),
        .expired_o (expired)
    );

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        addr_d     = addr_q;
        inst_d     = inst_q;
        iaddr_d    = iaddr_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        aerr_d     = 1'b0;
        stallreq_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if ((ce_i == ChipEnable) && !redirect) begin
                    if (pc_i[2:0] == 3'b000) begin
                        state_d = BUSY;
                        req_d   = 1'b1;
                        addr_d  = pc_i;
                    end else begin
                        aerr_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                stallreq_o = !ibus_ack_i;
                if (!ibus_ack_i && expired) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                end else if (redirect) begin
                    // The bus cannot cancel; without ack we must drain it.
                    if (ibus_ack_i) begin
                        state_d = IDLE;
                        req_d   = 1'b0;
                    end else begin
                        state_d = DROP;
                    end
                end else if (ibus_ack_i) begin
                    req_d   = 1'b0;
                    inst_d  = ibus_rdata_i;
                    iaddr_d = addr_q;
                    valid_d = 1'b1;
                    state_d = dec_stall ? HOLD : IDLE;
                end
            end
            DROP: begin
                stallreq_o = 1'b1;
                if (ibus_ack_i) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end else if (expired) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                end
            end
            HOLD: begin
                valid_d = dec_stall && !flush_i;
                if (flush_i || !dec_stall) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            inst_q  <= '0;
            iaddr_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            aerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            inst_q  <= inst_d;
            iaddr_q <= iaddr_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            aerr_q  <= aerr_d;
        end
    end

    assign ibus_req_o   = req_q;
    assign ibus_addr_o  = addr_q;
    assign inst_o       = inst_q;
    assign inst_addr_o  = iaddr_q;
    assign inst_valid_o = valid_q;
    assign ibus_err_o   = err_q;
    assign align_err_o  = aerr_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed and random checks of fetch_ctrl against a transaction-level model.
module tb_fetch_ctrl;

    localparam int TO = 4;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        ce;
    logic [5:0]  stall;
    logic        flush;
    logic        br;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [63:0] rdata;
    logic [63:0] inst;
    logic [31:0] iaddr;
    logic        valid;
    logic        sreq;
    logic        err;
    logic        aerr;

    fetch_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_i          (pc),
        .ce_i          (ce),
        .stall_i       (stall),
        .flush_i       (flush),
        .branch_flag_i (br),
        .ibus_req_o    (req),
        .ibus_addr_o   (addr),
        .ibus_ack_i    (ack),
        .ibus_rdata_i  (rdata),
        .inst_o        (inst),
        .inst_addr_o   (iaddr),
        .inst_valid_o  (valid),
        .stallreq_o    (sreq),
        .ibus_err_o    (err),
        .align_err_o   (aerr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: a fetch is either outstanding (maybe to be discarded),
    // or a delivered pair is being held for decode, or nothing happens.
    bit          m_init = 0;
    bit          m_out, m_disc, m_hold;
    int          m_age;
    logic        m_req, m_valid, m_err, m_aerr;
    logic [31:0] m_addr, m_iaddr;
    logic [63:0] m_inst;

    int c_req, c_valid, c_err, c_aerr, c_sreq;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clock();
        bit timeout;
        m_err  = 0;
        m_aerr = 0;
        if (rst) begin
            m_init = 1;
            {m_out, m_disc, m_hold} = '0;
            m_age = 0;
            {m_req, m_valid} = '0;
            m_addr = 0; m_iaddr = 0; m_inst = 0;
        end else if (m_out) begin
            timeout = !ack && (m_age == TO - 1);
            m_valid = 0;
            if (timeout) begin
                m_out = 0; m_req = 0; m_err = 1;
            end else if (!m_disc && (flush || br)) begin
                if (ack) begin
                    m_out = 0; m_req = 0;
                end else begin
                    m_disc = 1; m_age++;
                end
            end else if (ack) begin
                m_out = 0; m_req = 0;
                if (!m_disc) begin
                    m_inst = rdata; m_iaddr = m_addr;
                    m_valid = 1; m_hold = stall[1];
                end
            end else begin
                m_age++;
            end
        end else if (m_hold) begin
            if (flush || !stall[1]) begin
                m_hold = 0; m_valid = 0;
            end
        end else begin
            m_valid = 0;
            if (ce && !flush && !br) begin
                if (pc % 8 == 0) begin
                    m_out = 1; m_disc = 0; m_age = 0;
                    m_req = 1; m_addr = pc;
                end else begin
                    m_aerr = 1;
                end
            end
        end
    endtask

    task automatic step();
        #3;
        if (m_init) begin
            chk("stallreq", 64'(sreq), 64'(m_out && (m_disc || !ack)));
            c_sreq += int'(sreq);
        end
        @(posedge clk);
        model_clock();
        #1;
        chk("req", 64'(req), 64'(m_req));
        chk("addr", 64'(addr), 64'(m_addr));
        chk("inst", inst, m_inst);
        chk("inst_addr", 64'(iaddr), 64'(m_iaddr));
        chk("valid", 64'(valid), 64'(m_valid));
        chk("ibus_err", 64'(err), 64'(m_err));
        chk("align_err", 64'(aerr), 64'(m_aerr));
        c_req   += int'(req === 1'b1);
        c_valid += int'(valid === 1'b1);
        c_err   += int'(err === 1'b1);
        c_aerr  += int'(aerr === 1'b1);
    endtask

    task automatic clr_counts();
        c_req = 0; c_valid = 0; c_err = 0; c_aerr = 0; c_sreq = 0;
    endtask

    initial begin
        rst = 1; pc = 0; ce = 0; stall = 0; flush = 0; br = 0;
        ack = 0; rdata = 0;
        clr_counts();
        @(posedge clk);
        #1;
        step();
        rst = 0;

        // basic fetch, ack in third request cycle
        clr_counts();
        ce = 1; pc = 32'h0; step();
        ce = 0; step(); step();
        ack = 1; rdata = 64'h11112222_33334444; step();
        ack = 0; step(); step();
        chk("t1_req_cycles", 64'(c_req), 64'd3);
        chk("t1_stall_cycles", 64'(c_sreq), 64'd2);
        chk("t1_valid_pulses", 64'(c_valid), 64'd1);
        chk("t1_inst", inst, 64'h11112222_33334444);

        // branch redirect while outstanding
        clr_counts();
        ce = 1; pc = 32'h8; step();
        ce = 0; br = 1; step();
        br = 0; step();
        ack = 1; rdata = 64'hdead_beef_0000_0001; step();
        ack = 0; ce = 1; pc = 32'h40; step();
        chk("t2_valid_pulses", 64'(c_valid), 64'd0);
        chk("t2_new_addr", 64'(addr), 64'h40);
        ce = 0; ack = 1; rdata = 64'h5; step();
        ack = 0; step();

        // flush coincident with ack
        clr_counts();
        ce = 1; pc = 32'h10; step();
        ce = 0; step();
        flush = 1; ack = 1; rdata = 64'hbad; step();
        flush = 0; ack = 0; step();
        chk("t3_valid_pulses", 64'(c_valid), 64'd0);

        // decode stall at ack holds the pair
        ce = 1; pc = 32'h18; step();
        ce = 0; step();
        clr_counts();
        stall = 6'b000010; ack = 1; rdata = 64'hcafe_f00d_1234_5678;
        ce = 1; pc = 32'h20; step();
        ack = 0; step(); step(); step();
        stall = 0; step();
        chk("t4_valid_cycles", 64'(c_valid), 64'd4);
        chk("t4_req_in_hold", 64'(c_req), 64'd0);
        chk("t4_stallreq", 64'(c_sreq), 64'd0);
        ce = 0; step();
        ack = 1; step();
        ack = 0; step();

        // timeout
        clr_counts();
        ce = 1; pc = 32'h28; step();
        ce = 0; step(); step(); step(); step();
        chk("t5_req_cycles", 64'(c_req), 64'd4);
        chk("t5_err", 64'(err), 64'd1);
        chk("t5_req_low", 64'(req), 64'd0);
        ce = 1; pc = 32'h30; step();
        chk("t5_relaunch", 64'(req), 64'd1);
        ce = 0; ack = 1; step();
        ack = 0; step();

        // misaligned PC, then reset during BUSY and a late ack
        clr_counts();
        ce = 1; pc = 32'h4; step();
        chk("t6_aerr", 64'(aerr), 64'd1);
        ce = 0; step();
        ce = 1; pc = 32'h38; step();
        ce = 0; step();
        rst = 1; step();
        chk("t6_rst_req", 64'(req), 64'd0);
        rst = 0; ack = 1; step();
        ack = 0; step();
        chk("t6_late_ack", 64'(valid), 64'd0);
        chk("t6_aerr_pulses", 64'(c_aerr), 64'd1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 199) == 0);
            ce    = ($urandom_range(0, 1) == 1);
            pc    = $urandom & 32'hffff_fff8;
            if ($urandom_range(0, 9) == 0) pc[2:0] = 3'($urandom_range(1, 7));
            stall = ($urandom_range(0, 9) < 3) ? 6'b000010 : 6'($urandom) & 6'b111101;
            flush = ($urandom_range(0, 29) == 0);
            br    = ($urandom_range(0, 19) == 0);
            ack   = ($urandom_range(0, 9) < 3);
            rdata = {$urandom, $urandom};
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
